// File: rtl/reg_bank_arb_pkg.sv
// Shared types and defaults for the register-bank arbiter.
package reg_bank_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam int NREQ_DEF  = 4;
    localparam int NREG_DEF  = 8;
    localparam int WIDTH_DEF = 32;
    localparam int AW_DEF    = 8;

    function automatic int gw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/reg_bank_arb_if.sv
// Requester and bank-side bus of the register-bank arbiter.
import reg_bank_pkg::*;

interface reg_bank_arb_if #(
    parameter int NREQ  = NREQ_DEF,
    parameter int NREG  = NREG_DEF,
    parameter int WIDTH = WIDTH_DEF,
    parameter int AW    = AW_DEF
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_we;
    logic [NREQ*AW-1:0]    req_addr;
    logic [NREQ*WIDTH-1:0] req_wdata;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0]       rsp_valid;
    logic [WIDTH-1:0]      rsp_rdata;
    logic                  rsp_err;
    logic [NREG-1:0]       bank_we;
    logic [WIDTH-1:0]      bank_din;
    logic [NREG*WIDTH-1:0] bank_dout;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, bank_dout,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output bank_we, bank_din
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, bank_dout,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  bank_we, bank_din
    );
endinterface

// File: rtl/reg_bank_arb_rr_pick.sv
// Circular priority encoder: first set request after ptr_i.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int GW   = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [GW-1:0]   ptr_i,
    output logic [GW-1:0]   idx_o,
    output logic            any_o
);
    logic hit;

    always_comb begin
        idx_o = '0;
        hit   = 1'b0;
        any_o = |req_i;
        for (int k = 1; k <= NREQ; k++) begin
            if (!hit && req_i[(int'(ptr_i) + k) % NREQ]) begin
                idx_o = GW'((int'(ptr_i) + k) % NREQ);
                hit   = 1'b1;
            end
        end
    end
endmodule

// File: rtl/reg_bank_arb.sv
// Round-robin arbiter sequencing single-word accesses to a register bank.
import reg_bank_pkg::*;

module reg_bank_arb #(
    parameter int NREQ  = NREQ_DEF,
    parameter int NREG  = NREG_DEF,
    parameter int WIDTH = WIDTH_DEF,
    parameter int AW    = AW_DEF
) (
    input logic           clk,
    input logic           rstn,
    reg_bank_arb_if.slave bus
);
    localparam int GW = gw(NREQ);

    state_t            state_q, state_d;
    logic [GW-1:0]     grant_q, grant_d;
    logic [GW-1:0]     rr_q, rr_d;
    logic [WIDTH-1:0]  rdata_q, rdata_d;
    logic              err_q, err_d;

    logic [GW-1:0]     pick;
    logic              any;
    logic              vld_g, we_g, in_rng, acc;
    logic [AW-1:0]     addr_g;
    logic [WIDTH-1:0]  wdata_g, dout_a;

    logic [NREQ-1:0]   ready, rvalid;
    logic [NREG-1:0]   we;
    logic [WIDTH-1:0]  din, rdata;
    logic              err;

    rr_pick #(.NREQ(NREQ), .GW(GW)) u_pick (
        .req_i (bus.req_valid),
        .ptr_i (rr_q),
        .idx_o (pick),
        .any_o (any)
    );

    always_comb begin
        vld_g   = bus.req_valid[grant_q];
        we_g    = bus.req_we[grant_q];
        addr_g  = bus.req_addr[int'(grant_q)*AW +: AW];
        wdata_g = bus.req_wdata[int'(grant_q)*WIDTH +: WIDTH];
        in_rng  = 32'(addr_g) < 32'(NREG);
        dout_a  = '0;
        for (int r = 0; r < NREG; r++) begin
            if (32'(addr_g) == 32'(r))
                dout_a = bus.bank_dout[r*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            grant_q <= '0;
            rr_q    <= GW'(NREQ - 1);
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (any) begin
                    grant_d = pick;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                // A withdrawn request leaves the pointer where it was
                if (vld_g) begin
                    state_d = RESP;
                    rr_d    = grant_q;
                    err_d   = !in_rng;
                    if (!in_rng)
                        rdata_d = '0;
                    else if (we_g)
                        rdata_d = wdata_g;
                    else
                        rdata_d = dout_a;
                end else begin
                    state_d = IDLE;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready  = '0;
        rvalid = '0;
        we     = '0;
        din    = '0;
        rdata  = '0;
        err    = 1'b0;
        acc    = (state_q == ACCESS) && vld_g;
        if (acc) begin
            ready[grant_q] = 1'b1;
            if (we_g && in_rng) begin
                din = wdata_g;
                for (int r = 0; r < NREG; r++)
                    we[r] = (32'(addr_g) == 32'(r));
            end
        end
        if (state_q == RESP) begin
            rvalid[grant_q] = 1'b1;
            rdata           = rdata_q;
            err             = err_q;
        end
    end

    assign bus.req_ready = ready;
    assign bus.rsp_valid = rvalid;
    assign bus.rsp_rdata = rdata;
    assign bus.rsp_err   = err;
    assign bus.bank_we   = we;
    assign bus.bank_din  = din;
endmodule

// File: tb/tb_reg_bank_arb.sv
// Directed bench for reg_bank_arb with a behavioural register bank.
module tb_reg_bank_arb;
    logic clk;
    logic rstn;
    int   total;
    int   bad;

    logic [31:0] mem [8];

    reg_bank_arb_if #(.NREQ(4), .NREG(8), .WIDTH(32), .AW(8)) bus ();

    reg_bank_arb #(.NREQ(4), .NREG(8), .WIDTH(32), .AW(8)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int r = 0; r < 8; r++) mem[r] = '0;
    end

    always @(posedge clk) begin
        for (int r = 0; r < 8; r++)
            if (bus.bank_we[r]) mem[r] <= bus.bank_din;
    end

    always_comb begin
        bus.bank_dout = '0;
        for (int r = 0; r < 8; r++)
            bus.bank_dout[r*32 +: 32] = mem[r];
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_req();
        bus.req_valid = '0;
        bus.req_we    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
    endtask

    task automatic set_req(input int i, input bit w,
                           input logic [7:0] a, input logic [31:0] d);
        bus.req_valid[i]        = 1'b1;
        bus.req_we[i]           = w;
        bus.req_addr[i*8 +: 8]  = a;
        bus.req_wdata[i*32 +: 32] = d;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        clear_req();
        #3;
        total++;
        if (bus.req_ready !== 4'b0 || bus.rsp_valid !== 4'b0) begin
            bad++;
            $display("FAIL reset_hs rdy=%b rsp=%b exp 0",
                     bus.req_ready, bus.rsp_valid);
        end
        total++;
        if (bus.bank_we !== 8'b0 || bus.bank_din !== 32'b0) begin
            bad++;
            $display("FAIL reset_bank we=%b din=%h exp 0",
                     bus.bank_we, bus.bank_din);
        end
        total++;
        if (bus.rsp_rdata !== 32'b0 || bus.rsp_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_rsp rdata=%h err=%b exp 0",
                     bus.rsp_rdata, bus.rsp_err);
        end
        cyc();
        rstn = 1'b1;
        cyc();
    endtask

    task automatic test_single_write();
        set_req(0, 1'b1, 8'd3, 32'hDEADBEEF);
        cyc();
        total++;
        if (bus.req_ready !== 4'b0001) begin
            bad++;
            $display("FAIL wr_ready got=%b exp=0001", bus.req_ready);
        end
        total++;
        if (bus.bank_we !== 8'b0000_1000 || bus.bank_din !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL wr_bank we=%b din=%h exp 00001000 deadbeef",
                     bus.bank_we, bus.bank_din);
        end
        cyc();
        clear_req();
        total++;
        if (bus.rsp_valid !== 4'b0001 || bus.rsp_err !== 1'b0) begin
            bad++;
            $display("FAIL wr_rsp rsp=%b err=%b exp 0001 0",
                     bus.rsp_valid, bus.rsp_err);
        end
        total++;
        if (mem[3] !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL wr_mem got=%h exp=deadbeef", mem[3]);
        end
        cyc();
        cyc();
    endtask

    task automatic test_read_back();
        set_req(2, 1'b0, 8'd3, 32'h0);
        cyc();
        total++;
        if (bus.req_ready !== 4'b0100 || bus.bank_we !== 8'b0) begin
            bad++;
            $display("FAIL rd_access rdy=%b we=%b exp 0100 0",
                     bus.req_ready, bus.bank_we);
        end
        cyc();
        clear_req();
        total++;
        if (bus.rsp_valid !== 4'b0100 || bus.rsp_rdata !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL rd_rsp rsp=%b data=%h exp 0100 deadbeef",
                     bus.rsp_valid, bus.rsp_rdata);
        end
        total++;
        if (bus.bank_we !== 8'b0) begin
            bad++;
            $display("FAIL rd_nowe got=%b exp=0", bus.bank_we);
        end
        cyc();
        cyc();
    endtask

    task automatic test_contention();
        int ord [5] = '{0, 1, 2, 3, 0};
        logic [3:0] er;
        logic [3:0] ev;
        rstn = 1'b0;
        for (int i = 0; i < 4; i++) set_req(i, 1'b0, 8'(i), 32'h0);
        cyc();
        rstn = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            cyc();
            er = (c % 3 == 1) ? 4'(1 << ord[(c-1)/3]) : 4'b0;
            ev = (c % 3 == 2) ? 4'(1 << ord[(c-2)/3]) : 4'b0;
            total++;
            if (bus.req_ready !== er || bus.rsp_valid !== ev) begin
                bad++;
                $display("FAIL cont_c%0d rdy=%b rsp=%b exp %b %b",
                         c, bus.req_ready, bus.rsp_valid, er, ev);
            end
            total++;
            if (!$onehot0(bus.req_ready) || !$onehot0(bus.rsp_valid)) begin
                bad++;
                $display("FAIL cont_onehot_c%0d rdy=%b rsp=%b exp onehot",
                         c, bus.req_ready, bus.rsp_valid);
            end
        end
        clear_req();
        cyc();
        cyc();
    endtask

    task automatic test_out_of_range();
        set_req(1, 1'b1, 8'd8, 32'hCAFEF00D);
        cyc();
        total++;
        if (bus.req_ready !== 4'b0010 || bus.bank_we !== 8'b0) begin
            bad++;
            $display("FAIL oor_access rdy=%b we=%b exp 0010 0",
                     bus.req_ready, bus.bank_we);
        end
        cyc();
        clear_req();
        total++;
        if (bus.rsp_valid !== 4'b0010 || bus.rsp_err !== 1'b1 ||
            bus.rsp_rdata !== 32'h0) begin
            bad++;
            $display("FAIL oor_rsp rsp=%b err=%b data=%h exp 0010 1 0",
                     bus.rsp_valid, bus.rsp_err, bus.rsp_rdata);
        end
        cyc();
        cyc();
    endtask

    task automatic test_withdraw();
        rstn = 1'b0;
        clear_req();
        cyc();
        rstn = 1'b1;
        cyc();
        set_req(3, 1'b1, 8'd2, 32'h1234_5678);
        cyc();
        bus.req_valid[3] = 1'b0;
        #1;
        total++;
        if (bus.req_ready !== 4'b0 || bus.bank_we !== 8'b0) begin
            bad++;
            $display("FAIL wd_access rdy=%b we=%b exp 0 0",
                     bus.req_ready, bus.bank_we);
        end
        cyc();
        total++;
        if (bus.rsp_valid !== 4'b0 || mem[2] !== 32'h0) begin
            bad++;
            $display("FAIL wd_idle rsp=%b mem2=%h exp 0 0",
                     bus.rsp_valid, mem[2]);
        end
        clear_req();
        set_req(0, 1'b0, 8'd0, 32'h0);
        set_req(3, 1'b0, 8'd1, 32'h0);
        cyc();
        total++;
        if (bus.req_ready !== 4'b0001) begin
            bad++;
            $display("FAIL wd_regrant got=%b exp=0001", bus.req_ready);
        end
        cyc();
        total++;
        if (bus.rsp_valid !== 4'b0001) begin
            bad++;
            $display("FAIL wd_rsp got=%b exp=0001", bus.rsp_valid);
        end
        clear_req();
        cyc();
        cyc();
    endtask

    task automatic test_reset_midop();
        set_req(0, 1'b1, 8'd5, 32'hA5A5_5A5A);
        cyc();
        total++;
        if (bus.bank_we !== 8'b0010_0000) begin
            bad++;
            $display("FAIL mid_we got=%b exp=00100000", bus.bank_we);
        end
        rstn = 1'b0;
        #1;
        total++;
        if (bus.req_ready !== 4'b0 || bus.bank_we !== 8'b0 ||
            bus.bank_din !== 32'h0 || bus.rsp_valid !== 4'b0) begin
            bad++;
            $display("FAIL mid_rst rdy=%b we=%b din=%h rsp=%b exp 0",
                     bus.req_ready, bus.bank_we, bus.bank_din, bus.rsp_valid);
        end
        clear_req();
        set_req(1, 1'b0, 8'd1, 32'h0);
        set_req(2, 1'b0, 8'd2, 32'h0);
        cyc();
        cyc();
        total++;
        if (mem[5] !== 32'h0) begin
            bad++;
            $display("FAIL mid_mem got=%h exp=0", mem[5]);
        end
        rstn = 1'b1;
        cyc();
        total++;
        if (bus.req_ready !== 4'b0010) begin
            bad++;
            $display("FAIL mid_g1 got=%b exp=0010", bus.req_ready);
        end
        cyc();
        total++;
        if (bus.rsp_valid !== 4'b0010) begin
            bad++;
            $display("FAIL mid_rsp1 got=%b exp=0010", bus.rsp_valid);
        end
        bus.req_valid[1] = 1'b0;
        cyc();
        cyc();
        total++;
        if (bus.req_ready !== 4'b0100) begin
            bad++;
            $display("FAIL mid_g2 got=%b exp=0100", bus.req_ready);
        end
        cyc();
        clear_req();
        cyc();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rstn  = 1'b0;
        clear_req();
        test_reset();
        test_single_write();
        test_read_back();
        test_contention();
        test_out_of_range();
        test_withdraw();
        test_reset_midop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/reg_bank_arb.md
Name: reg_bank_arb

Overview:
- Round-robin arbiter and sequencer sharing one bank of write-enable registers (NREG words of WIDTH bits) among NREQ requesters.
- Each requester issues single-word read or write transactions over a valid/ready request and a one-cycle response pulse.
- The block drives per-register write strobes and a shared write-data bus, and selects read data from the bank's flattened outputs.
- Sits between CPU/peripheral masters and the register bank inside the common RTL layer.

Parameters:
- NREQ, 4, number of requesters (2..8).
- NREG, 8, number of registers in the bank (2..256).
- WIDTH, 32, register data width.
- AW, 8, request address width; addresses >= NREG are out of range.

Ports:
- clk  in  1  clock
- rstn  in  1  reset
- req_valid  in  NREQ  request valid per requester
- req_we  in  NREQ  1 = write, 0 = read
- req_addr  in  NREQ*AW  packed addresses; requester i at [i*AW +: AW]
- req_wdata  in  NREQ*WIDTH  packed write data; requester i at [i*WIDTH +: WIDTH]
- req_ready  out  NREQ  one-hot accept pulse
- rsp_valid  out  NREQ  one-hot response pulse
- rsp_rdata  out  WIDTH  response data, shared by all requesters
- rsp_err  out  1  response error (address out of range), qualified by any rsp_valid
- bank_we  out  NREG  one-hot write strobe to the bank registers
- bank_din  out  WIDTH  shared write data to the bank
- bank_dout  in  NREG*WIDTH  packed bank outputs; register r at [r*WIDTH +: WIDTH]

Behaviour:
- Reset is rstn, asynchronous, active-low; clock is clk.
- During reset:
  - state = IDLE, rr_ptr = NREQ-1, grant = 0.
  - req_ready, rsp_valid, bank_we, rsp_err = 0; rsp_rdata, bank_din = 0.
- FSM has states IDLE, ACCESS, RESP.
- IDLE:
  - If any req_valid bit is set, register grant g = first set bit searching circularly from rr_ptr+1, then go to ACCESS.
  - Otherwise stay in IDLE. All outputs are 0.
- ACCESS (one cycle), when req_valid[g] = 1:
  - Assert req_ready[g] combinationally.
  - Write with addr < NREG: bank_we[addr] = 1, bank_din = wdata[g]; the register updates on this clock edge. Latch rdata = wdata[g] and err = 0.
  - Read with addr < NREG: latch rdata = bank_dout[addr], err = 0.
  - addr >= NREG: no bank_we; latch rdata = 0, err = 1.
  - Next state is RESP; rr_ptr <= g.
- ACCESS, when req_valid[g] = 0 (requester withdrew): no ready, no write, no response. Go to IDLE; rr_ptr is unchanged.
- RESP (one cycle): rsp_valid[g] = 1, rsp_rdata = rdata, rsp_err = err. Next state is IDLE.
- bank_din equals wdata[g] only while bank_we is nonzero, and 0 otherwise.
- Timing:
  - Latency from valid seen in IDLE to ready is 1 cycle; rsp_valid follows ready by 1 cycle.
  - Maximum throughput is 1 transaction per 3 cycles.
- Requester protocol: hold req_valid, req_we, req_addr and req_wdata stable until req_ready. Payload changes before ready are sampled in the ACCESS cycle.
- Read data reflects the bank contents at the ACCESS cycle, including writes completed by earlier transactions.
- Fairness:
  - After requester g is served, g has the lowest priority on the next grant.
  - A continuously requesting requester waits at most NREQ-1 transactions.
- Simultaneous requests arriving in the same cycle are resolved purely by rr_ptr order.
- Reset mid-operation: a write strobe in progress is dropped and a pending response is lost; the FSM returns to IDLE with rr_ptr = NREQ-1.
- At most one bit of req_ready, rsp_valid or bank_we is ever set.

Decomposition:
- Package reg_bank_pkg holds:
  - enum state_t {IDLE, ACCESS, RESP}
  - default-parameter constants
  - a clog2-based GW = $clog2(NREQ) constant function
- One sub-module, rr_pick: combinational circular priority encoder.
  - Inputs: req[NREQ], ptr[GW].
  - Outputs: idx[GW], any.

Test Plan:
- Single write: requester 0 writes addr 3, data 0xDEADBEEF.
  - req_ready[0] asserts 1 cycle after valid, with bank_we = 8'b0000_1000 and bank_din = 0xDEADBEEF in the same cycle.
  - Next cycle: rsp_valid[0] = 1, rsp_err = 0.
- Read-back: requester 2 reads addr 3, with the bank model holding 0xDEADBEEF.
  - rsp_valid[2] = 1, rsp_rdata = 0xDEADBEEF; bank_we stays 0 throughout.
- Contention: all 4 requesters hold valid from reset.
  - Grants occur in order 0, 1, 2, 3, 0, at 3-cycle spacing.
  - req_ready and rsp_valid are always one-hot.
- Out of range: requester 1 writes addr 8 (NREG = 8).
  - No bank_we bit is set; rsp_valid[1] = 1 with rsp_err = 1 and rsp_rdata = 0.
- Withdrawal: requester 3 drops valid in the cycle FSM enters ACCESS.
  - No req_ready, no bank_we, no rsp_valid; FSM returns to IDLE.
  - The next grant with requesters 0 and 3 pending goes to 0.
- Reset mid-op: assert rstn = 0 during ACCESS of a write.
  - All outputs go to 0 immediately.
  - After release, requesters 1 and 2 pending get grant order 0-first search: 1 then 2.
